// File: rtl/vending_pkg.sv
// Shared vending definitions: coin codes, coin values and the
// change dispenser state encoding.
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    localparam int unsigned VAL_5  = 5;
    localparam int unsigned VAL_10 = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAULT    = 3'd4
    } disp_state_e;

    // Rupee value of a coin code; 0 for none/illegal codes.
    function automatic logic [3:0] coin_value(input logic [1:0] code);
        logic [3:0] v;
        v = 4'd0;
        case (code)
            COIN_5:  v = 4'(VAL_5);
            COIN_10: v = 4'(VAL_10);
            default: v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a rupee amount one coin per hopper handshake,
// preferring 10 Rs coins, and reports completion or the unpaid shortfall.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   req_valid/ready/amount payout request handshake (ready == IDLE)
//   coin_out              registered coin code to the hopper
//   eject_ack             hopper ejected the coin on coin_out
//   empty5, empty10       hopper tube empty flags (sampled in SELECT)
//   busy                  not IDLE
//   done, fault           one-cycle completion / abort pulses
//   shortfall             unpaid amount, held until the next done/fault
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    output logic [1:0]       coin_out,
    input  logic             eject_ack,
    input  logic             empty5,
    input  logic             empty10,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] shortfall
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [AMT_W-1:0] AMT_5    = AMT_W'(VAL_5);
    localparam logic [AMT_W-1:0] AMT_10   = AMT_W'(VAL_10);

    disp_state_e      state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [1:0]       coin_q, coin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic [AMT_W-1:0] short_q, short_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            coin_q  <= COIN_NONE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            short_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            coin_q  <= coin_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            short_q <= short_d;
        end
    end

    // done/fault are registered alongside the state change, so each
    // pulse coincides exactly with the DONE/FAULT state cycle.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        coin_d  = coin_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        short_d = short_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rem_d = req_amount;
                    if ((req_amount % AMT_5) != '0) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        short_d = req_amount;
                    end else begin
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_SELECT: begin
                cnt_d = '0;
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    short_d = '0;
                end else if (rem_q >= AMT_10 && !empty10) begin
                    coin_d  = COIN_10;
                    state_d = ST_WAIT_ACK;
                end else if (rem_q >= AMT_5 && !empty5) begin
                    coin_d  = COIN_5;
                    state_d = ST_WAIT_ACK;
                end else begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    short_d = rem_q;
                end
            end
            ST_WAIT_ACK: begin
                // An ack on the last timeout cycle still counts as paid.
                if (eject_ack) begin
                    rem_d   = rem_q - AMT_W'(coin_value(coin_q));
                    coin_d  = COIN_NONE;
                    state_d = ST_SELECT;
                end else if (cnt_q == CNT_LAST) begin
                    coin_d  = COIN_NONE;
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    short_d = rem_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign coin_out  = coin_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign shortfall = short_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed table, hand-written
// reset/latency sequences and randomized payouts against a payout model.
module tb_change_dispenser;

    localparam int AMT_W = 8;
    localparam int ACK_TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset;
    logic req_valid;
    logic req_ready;
    logic [AMT_W-1:0] req_amount;
    logic [1:0] coin_out;
    logic eject_ack;
    logic empty5;
    logic empty10;
    logic busy;
    logic done;
    logic fault;
    logic [AMT_W-1:0] shortfall;

    int n_checks = 0;
    int n_fail = 0;

    // results of the last payout
    logic [15:0] r_coins;
    int r_n, r_hold, r_first, r_end;
    bit r_done, r_fin, r_err;
    logic [7:0] r_sf;

    typedef struct {
        logic [7:0]  amt;
        bit          e5;
        bit          e10;
        int          ack;
        int          n;
        logic [15:0] coins;
        bit          dn;
        logic [7:0]  sf;
        int          hold;
        int          endc;
    } vec_t;

    vec_t vecs[10];

    change_dispenser #(
        .AMT_W(AMT_W),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_amount(req_amount),
        .coin_out(coin_out),
        .eject_ack(eject_ack),
        .empty5(empty5),
        .empty10(empty10),
        .busy(busy),
        .done(done),
        .fault(fault),
        .shortfall(shortfall)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Greedy payout at transaction level: 10s first, then 5s.
    function automatic void model(input logic [7:0] amt, input bit e5,
                                  input bit e10, input bit never,
                                  output logic [15:0] coins, output int n,
                                  output bit ok, output logic [7:0] sf);
        int rem;
        rem = int'(amt);
        coins = '0;
        n = 0;
        ok = 1'b0;
        sf = amt;
        if (rem % 5 != 0) return;
        while (rem > 0) begin
            if (rem >= 10 && !e10) begin
                coins[2*n +: 2] = 2'b10;
                rem -= 10;
            end else if (rem >= 5 && !e5) begin
                coins[2*n +: 2] = 2'b01;
                rem -= 5;
            end else begin
                break;
            end
            n++;
            if (never) return;
        end
        ok = (rem == 0);
        sf = 8'(rem);
    endfunction

    // Issue one request and act as the hopper until done/fault.
    // ack_lat = k acks in the k-th cycle a coin is visible; 0 = never.
    task automatic pay(input logic [7:0] amt, input int ack_lat,
                       input bit noise);
        int held;
        logic [1:0] prev;
        held = 0;
        prev = 2'b00;
        r_coins = '0;
        r_n = 0; r_hold = 0; r_first = -1; r_end = -1;
        r_done = 1'b0; r_fin = 1'b0; r_err = 1'b0; r_sf = '0;
        @(negedge clk);
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_amount = amt;
        eject_ack = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            // requests while busy must be ignored
            req_amount = 8'($urandom);
            if (coin_out == 2'b11) r_err = 1'b1;
            if (coin_out != 2'b00 && prev != 2'b00 && coin_out != prev)
                r_err = 1'b1;
            prev = coin_out;
            if (coin_out != 2'b00) begin
                if (held == 0) begin
                    if (r_n < 8) r_coins[2*r_n +: 2] = coin_out;
                    if (r_n == 0) r_first = cyc;
                    r_n++;
                end
                held++;
                if (ack_lat != 0 && held > ack_lat) r_err = 1'b1;
                eject_ack = (ack_lat != 0 && held == ack_lat);
            end else begin
                if (held != 0) r_hold = held;
                held = 0;
                eject_ack = noise ? 1'($urandom) : 1'b0;
            end
            if (done || fault) begin
                r_done = done;
                r_sf = shortfall;
                r_end = cyc;
                r_fin = 1'b1;
                if (done && fault) r_err = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        eject_ack = 1'b0;
    endtask

    task automatic check_pay(input string nm, input logic [15:0] coins,
                             input int n, input bit dn, input logic [7:0] sf,
                             input int hold, input int endc);
        check({nm, ".finished"}, {31'd0, r_fin}, 32'd1);
        check({nm, ".protocol"}, {31'd0, r_err}, 32'd0);
        check({nm, ".ncoins"}, r_n, n);
        check({nm, ".coins"}, {16'd0, r_coins}, {16'd0, coins});
        check({nm, ".done"}, {31'd0, r_done}, {31'd0, dn});
        check({nm, ".shortfall"}, {24'd0, r_sf}, {24'd0, sf});
        if (n > 0) check({nm, ".first_lat"}, r_first, 1);
        if (hold >= 0) check({nm, ".hold"}, r_hold, hold);
        if (endc >= 0) check({nm, ".end_lat"}, r_end, endc);
        @(negedge clk);
        check({nm, ".ready_after"}, {31'd0, req_ready}, 32'd1);
        check({nm, ".pulse_width"}, {30'd0, done, fault}, 32'd0);
        check({nm, ".sf_hold"}, {24'd0, shortfall}, {24'd0, sf});
        check({nm, ".coin_idle"}, {30'd0, coin_out}, 32'd0);
    endtask

    initial begin
        logic [15:0] m_coins;
        int m_n, seen, hold;
        bit m_ok;
        logic [7:0] m_sf, amt;
        bit e5, e10, noise;
        int ack;
        logic [1:0] prevc;

        vecs[0] = '{8'd25, 1'b0, 1'b0, 1,  3, 16'h001A, 1'b1, 8'd0,  1,  7};
        vecs[1] = '{8'd20, 1'b0, 1'b1, 1,  4, 16'h0055, 1'b1, 8'd0,  1,  9};
        vecs[2] = '{8'd15, 1'b1, 1'b0, 1,  1, 16'h0002, 1'b0, 8'd5,  1,  3};
        vecs[3] = '{8'd7,  1'b0, 1'b0, 1,  0, 16'h0000, 1'b0, 8'd7, -1,  0};
        vecs[4] = '{8'd0,  1'b0, 1'b0, 1,  0, 16'h0000, 1'b1, 8'd0, -1,  1};
        vecs[5] = '{8'd10, 1'b0, 1'b0, 0,  1, 16'h0002, 1'b0, 8'd10, 15, 16};
        vecs[6] = '{8'd10, 1'b0, 1'b0, 15, 1, 16'h0002, 1'b1, 8'd0, 15, 17};
        vecs[7] = '{8'd35, 1'b0, 1'b0, 3,  4, 16'h006A, 1'b1, 8'd0,  3, 17};
        vecs[8] = '{8'd5,  1'b1, 1'b0, 1,  0, 16'h0000, 1'b0, 8'd5, -1,  1};
        vecs[9] = '{8'd10, 1'b1, 1'b1, 1,  0, 16'h0000, 1'b0, 8'd10, -1, 1};

        reset = 1'b1;
        req_valid = 1'b0;
        req_amount = '0;
        eject_ack = 1'b0;
        empty5 = 1'b0;
        empty10 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst.coin", {30'd0, coin_out}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.ready", {31'd0, req_ready}, 32'd1);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.fault", {31'd0, fault}, 32'd0);
        check("rst.sf", {24'd0, shortfall}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst.busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            empty5 = vecs[i].e5;
            empty10 = vecs[i].e10;
            pay(vecs[i].amt, vecs[i].ack, 1'b0);
            check_pay($sformatf("vec%0d", i), vecs[i].coins, vecs[i].n,
                      vecs[i].dn, vecs[i].sf, vecs[i].hold, vecs[i].endc);
        end

        // reset during the second coin of a 30 Rs payout
        empty5 = 1'b0;
        empty10 = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_amount = 8'd30;
        seen = 0;
        prevc = 2'b00;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (coin_out != 2'b00 && prevc == 2'b00) seen++;
            prevc = coin_out;
            if (seen == 2) break;
            eject_ack = (coin_out != 2'b00);
        end
        eject_ack = 1'b0;
        check("mid.second_coin", seen, 2);
        check("mid.busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid.coin", {30'd0, coin_out}, 32'd0);
        check("mid.busy", {31'd0, busy}, 32'd0);
        check("mid.pulses", {30'd0, done, fault}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid.quiet", {29'd0, done, fault, busy}, 32'd0);
        end
        pay(8'd5, 1, 1'b0);
        check_pay("after_rst", 16'h0001, 1, 1'b1, 8'd0, 1, 3);

        // randomized payouts with spurious acks outside WAIT_ACK
        for (int t = 0; t < 40; t++) begin
            amt = 8'($urandom_range(0, 40));
            e5 = ($urandom_range(0, 3) == 0);
            e10 = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            noise = 1'($urandom);
            empty5 = e5;
            empty10 = e10;
            model(amt, e5, e10, (ack == 0), m_coins, m_n, m_ok, m_sf);
            hold = (ack == 0) ? ACK_TIMEOUT : ack;
            pay(amt, ack, noise);
            check_pay($sformatf("rnd%0d_amt%0d", t, amt), m_coins, m_n,
                      m_ok, m_sf, (m_n > 0) ? hold : -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
